dilated_conv_scheduler: RTL and testbench
=========================================

# dilated_conv_scheduler

Sequencing controller for one `conv1d` layer in the cached dilated causal convolution stack. Accepts one D-element activation vector per time step and keeps a circular cache of past activations. It presents the four dilated taps x[t-3K], x[t-2K], x[t-K] and x[t] to `conv1d`, restarts `conv1d` for each sample, and waits for its valid. It then holds the layer output on a valid/ready handshake toward the next layer.

## Interface
Parameters:
- W, 16, bits per fixed-point element (4.12 format)
- D, 8, elements per packed vector
- DILATION, 1, dilation K (≥1); cache depth N = 3K+1
- TIMEOUT, 64, max cycles in WAIT before error

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  D*W  packed activation x[t], element 0 in MSBs
- in_v  in  1  input valid
- in_ready  out  1  input ready
- apply_relu  in  1  ReLU enable, sampled on accept
- conv_a0..conv_a3  out  D*W each  taps x[t-3K], x[t-2K], x[t-K], x[t]
- conv_rst  out  1  restart to `conv1d`
- conv_apply_relu  out  1  latched ReLU enable
- conv_out  in  D*W  `conv1d` result
- conv_out_v  in  1  `conv1d` result valid (level)
- out_data  out  D*W  registered layer output
- out_v  out  1  output valid
- out_ready  in  1  downstream ready
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, KICK, WAIT, HOLD.
- IDLE:
  - in_ready=1.
  - On in_v&&in_ready: write in_data to mem[wptr] and register the four taps.
  - Latch apply_relu into conv_apply_relu.
  - Advance wptr (wraps N-1→0), set fill=min(fill+1,3K), go to KICK.
- Tap addressing at accept, using wptr before increment:
  - conv_a3=in_data.
  - conv_a2=mem[(wptr-K) mod N].
  - conv_a1=mem[(wptr-2K) mod N].
  - conv_a0=mem[(wptr+1) mod N].
- Causal zero padding: tap with offset jK (j=1..3) outputs all-zero if fill<jK, where fill is the value before the accept. Cache RAM contents are never cleared.
- KICK: lasts one cycle with conv_rst=1 and taps stable, then go to WAIT.
- conv_rst=1 in IDLE, KICK and HOLD; 0 only in WAIT.
- WAIT: counter counts cycles in WAIT.
  - conv_out_v=1 at an edge: out_data<=conv_out, out_v<=1, go to HOLD.
  - Else counter reaches TIMEOUT-1: err<=1, out_data<=0, out_v<=1, go to HOLD.
- HOLD: out_data and out_v stable until out_v&&out_ready at an edge, then out_v<=0 and go to IDLE.
- Taps and conv_apply_relu change only on accept.
- No arithmetic on data; the scheduler only moves, stores or masks data.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, conv_rst=1, out_v=0, out_data=0, err=0.
  - conv_a0..a3=0, conv_apply_relu=0, wptr=0, fill=0, WAIT counter=0.
- Accept at edge E0: KICK after E0, WAIT after E1. With conv latency L, meaning conv_out_v is first seen at edge E1+L, out_v=1 after E1+L.
- Minimum interval between accepts: L+3 cycles, with out_ready tied high.
- in_ready and out_v are never both 1; input and output handshakes cannot coincide.
- out_ready held high before out_v rises: out_v lasts exactly one cycle.
- Reset asserted mid-operation (any state):
  - Immediate return to reset values.
  - Any in-flight output is lost.
  - Cache history is invalidated via fill=0.
- err is cleared only by rst. Operation continues normally after a timeout.

## Structure
- Shared package `conv_pkg`:
  - W and D defaults.
  - Scheduler state enum.
  - Fixed-point bound constants (-8, 7.999755859375) shared with `conv1d`.
- Sub-module `tap_cache`: N×(D*W) circular buffer with wptr, fill counter, dilated read addressing and zero masking. Parameters D, W, DILATION.
- `dilated_conv_scheduler` contains the FSM, timeout counter and output register, and instantiates `tap_cache`.

## Test plan
Bench uses a `conv1d` behavioural stub with L=10.
- Reset mid-WAIT (K=2): samples 1,2 accepted, rst pulsed during WAIT of sample 2 → out_v=0, in_ready=1. Next sample 9 gives taps (0,0,0,9), proving fill cleared.
- Fill and zero padding (K=2): vectors with all elements 1,2,3,… accepted → taps at the 7th accept are (1,3,5,7). Taps at the 3rd accept are (0,0,1,3).
- Wrap-around (K=1, N=4): 10 samples 1..10 → 10th taps (7,8,9,10). wptr after the 10th accept is 2.
- Backpressure: out_ready low for 20 cycles → out_data stable, in_ready=0, conv_rst=1 throughout. Release gives exactly one transfer.
- Timeout (TIMEOUT=64): stub never asserts conv_out_v → err=1, out_v=1 with out_data=0 at cycle 64 of WAIT. The next sample completes normally and err stays 1.
- ReLU latch: apply_relu toggled after accept → conv_apply_relu keeps the accept-time value until the next accept.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the dilated conv1d layer: default element geometry,
// scheduler states and the 4.12 fixed-point bounds used by conv1d.
package conv_pkg;

  localparam int W_DEF = 16;
  localparam int D_DEF = 8;

  // 4.12 format bounds: -8.0 and 7.999755859375
  localparam logic signed [15:0] FX_MIN = 16'sh8000;
  localparam logic signed [15:0] FX_MAX = 16'sh7fff;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KICK,
    S_WAIT,
    S_HOLD
  } sched_state_t;

endpackage

// File: rtl/tap_cache.sv
// Circular activation cache of depth 3K+1 producing the four dilated taps,
// zero-masked until enough history has been written since reset.
module tap_cache
  import conv_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int D        = D_DEF,
  parameter int DILATION = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [D*W-1:0] wdata,
  output logic [D*W-1:0] a0,
  output logic [D*W-1:0] a1,
  output logic [D*W-1:0] a2,
  output logic [D*W-1:0] a3
);

  localparam int N  = 3 * DILATION + 1;
  localparam int AW = $clog2(N);

  logic [D*W-1:0] mem [N];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  fill;

  function automatic logic [AW-1:0] back(input logic [AW-1:0] p, input int off);
    int s;
    s = int'(p) - off;
    if (s < 0) s = s + N;
    return AW'(s);
  endfunction

  // No reset on the RAM; history validity is tracked solely by fill.
  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0   <= '0;
      a1   <= '0;
      a2   <= '0;
      a3   <= '0;
      wptr <= '0;
      fill <= '0;
    end else if (we) begin
      a3 <= wdata;
      a2 <= (int'(fill) >= DILATION)     ? mem[back(wptr, DILATION)]     : '0;
      a1 <= (int'(fill) >= 2 * DILATION) ? mem[back(wptr, 2 * DILATION)] : '0;
      // (wptr - 3K) mod N is the slot just ahead of wptr
      a0 <= (int'(fill) >= 3 * DILATION) ? mem[back(wptr, 3 * DILATION)] : '0;
      wptr <= (wptr == AW'(N - 1)) ? '0 : wptr + 1'b1;
      if (int'(fill) < 3 * DILATION) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/dilated_conv_scheduler.sv
// Per-sample sequencer for one conv1d layer: capture taps, restart conv1d,
// wait for its result with a timeout, then hold it on a valid/ready output.
module dilated_conv_scheduler
  import conv_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int D        = D_DEF,
  parameter int DILATION = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D*W-1:0] in_data,
  input  logic           in_v,
  output logic           in_ready,
  input  logic           apply_relu,
  output logic [D*W-1:0] conv_a0,
  output logic [D*W-1:0] conv_a1,
  output logic [D*W-1:0] conv_a2,
  output logic [D*W-1:0] conv_a3,
  output logic           conv_rst,
  output logic           conv_apply_relu,
  input  logic [D*W-1:0] conv_out,
  input  logic           conv_out_v,
  output logic [D*W-1:0] out_data,
  output logic           out_v,
  input  logic           out_ready,
  output logic           err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  sched_state_t   state_q, state_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [D*W-1:0] out_data_d;
  logic           out_v_d;
  logic           err_d;
  logic           accept;

  assign accept = (state_q == S_IDLE) && in_v;

  tap_cache #(
    .W        (W),
    .D        (D),
    .DILATION (DILATION)
  ) u_cache (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .wdata (in_data),
    .a0    (conv_a0),
    .a1    (conv_a1),
    .a2    (conv_a2),
    .a3    (conv_a3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      out_data <= '0;
      out_v    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_data <= out_data_d;
      out_v    <= out_v_d;
      err      <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         conv_apply_relu <= 1'b0;
    else if (accept) conv_apply_relu <= apply_relu;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_data_d = out_data;
    out_v_d    = out_v;
    err_d      = err;
    in_ready   = (state_q == S_IDLE);
    conv_rst   = (state_q != S_WAIT);
    case (state_q)
      S_IDLE: if (in_v) state_d = S_KICK;
      S_KICK: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (conv_out_v) begin
          out_data_d = conv_out;
          out_v_d    = 1'b1;
          cnt_d      = '0;
          state_d    = S_HOLD;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          // Emit a zero result so the downstream pipeline keeps moving.
          err_d      = 1'b1;
          out_data_d = '0;
          out_v_d    = 1'b1;
          cnt_d      = '0;
          state_d    = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_v_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dilated_conv_scheduler.sv
// Bench for dilated_conv_scheduler: K=2 and K=1 instances, each with a conv1d
// stub of latency 10, and a reference tap model feeding a result scoreboard.
module tb_dilated_conv_scheduler;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int DW = D * W;
  localparam int L  = 10;

  typedef struct {
    logic [DW-1:0] data;
    logic          relu;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst        [2];
  logic [DW-1:0] in_data    [2];
  logic          in_v       [2];
  logic          in_ready   [2];
  logic          apply_relu [2];
  logic [DW-1:0] a0 [2], a1 [2], a2 [2], a3 [2];
  logic          conv_rst   [2];
  logic          conv_relu  [2];
  logic [DW-1:0] conv_out   [2];
  logic          conv_out_v [2];
  logic [DW-1:0] out_data   [2];
  logic          out_v      [2];
  logic          out_ready  [2];
  logic          err        [2];

  int  scnt    [2];
  bit  stub_en [2];
  bit  err_exp [2];
  int  hist    [2][64];
  int  hcnt    [2];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dilated_conv_scheduler #(.W(W), .D(D), .DILATION(2), .TIMEOUT(64)) u_k2 (
    .clk(clk), .rst(rst[0]), .in_data(in_data[0]), .in_v(in_v[0]), .in_ready(in_ready[0]),
    .apply_relu(apply_relu[0]), .conv_a0(a0[0]), .conv_a1(a1[0]), .conv_a2(a2[0]),
    .conv_a3(a3[0]), .conv_rst(conv_rst[0]), .conv_apply_relu(conv_relu[0]),
    .conv_out(conv_out[0]), .conv_out_v(conv_out_v[0]), .out_data(out_data[0]),
    .out_v(out_v[0]), .out_ready(out_ready[0]), .err(err[0])
  );

  dilated_conv_scheduler #(.W(W), .D(D), .DILATION(1), .TIMEOUT(64)) u_k1 (
    .clk(clk), .rst(rst[1]), .in_data(in_data[1]), .in_v(in_v[1]), .in_ready(in_ready[1]),
    .apply_relu(apply_relu[1]), .conv_a0(a0[1]), .conv_a1(a1[1]), .conv_a2(a2[1]),
    .conv_a3(a3[1]), .conv_rst(conv_rst[1]), .conv_apply_relu(conv_relu[1]),
    .conv_out(conv_out[1]), .conv_out_v(conv_out_v[1]), .out_data(out_data[1]),
    .out_v(out_v[1]), .out_ready(out_ready[1]), .err(err[1])
  );

  // conv1d stub: result valid from the L-th WAIT edge on, a simple tap mix
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (conv_rst[i]) scnt[i] <= 0;
      else             scnt[i] <= scnt[i] + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      conv_out_v[i] = stub_en[i] && !conv_rst[i] && (scnt[i] >= L - 1);
      conv_out[i]   = a0[i] ^ a1[i] ^ a2[i] ^ ~a3[i];
    end
  end

  function automatic logic [DW-1:0] vec(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < D; i++) r[i*W +: W] = 16'(v);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic accept_s(input int idx, input int val, input bit relu);
    int   k;
    int   t[4];
    int   n;
    exp_t e;
    k = (idx == 0) ? 2 : 1;
    n = 0;
    while (!in_ready[idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready[idx], 1);
    for (int j = 1; j <= 3; j++)
      t[3-j] = (hcnt[idx] >= j * k) ? hist[idx][hcnt[idx] - j * k] : 0;
    t[3] = val;
    in_data[idx]    = vec(val);
    apply_relu[idx] = relu;
    in_v[idx]       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_v[idx] = 1'b0;
    if (hcnt[idx] < 64) begin
      hist[idx][hcnt[idx]] = val;
      hcnt[idx]++;
    end
    chk("tap_a0", a0[idx], vec(t[0]));
    chk("tap_a1", a1[idx], vec(t[1]));
    chk("tap_a2", a2[idx], vec(t[2]));
    chk("tap_a3", a3[idx], vec(t[3]));
    chk("relu_latch", conv_relu[idx], relu);
    e.data = vec(t[0]) ^ vec(t[1]) ^ vec(t[2]) ^ ~vec(t[3]);
    e.relu = relu;
    sb.push_back(e);
  endtask

  task automatic complete_s(input int idx, input bit tmo, input int hold);
    exp_t          e;
    logic [DW-1:0] want;
    int            n;
    e    = sb.pop_front();
    want = tmo ? '0 : e.data;
    n    = 0;
    apply_relu[idx] = ~apply_relu[idx];
    while (!out_v[idx] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (tmo) err_exp[idx] = 1'b1;
    chk("latency", n, tmo ? 65 : L + 1);
    chk("out_data", out_data[idx], want);
    chk("err", err[idx], err_exp[idx]);
    chk("relu_hold", conv_relu[idx], e.relu);
    chk("in_ready_busy", in_ready[idx], 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_data", out_data[idx], want);
      chk("bp_out_v", out_v[idx], 1);
      chk("bp_in_ready", in_ready[idx], 0);
      chk("bp_conv_rst", conv_rst[idx], 1);
    end
    out_ready[idx] = 1'b1;
    @(negedge clk);
    chk("out_v_drop", out_v[idx], 0);
    chk("in_ready_back", in_ready[idx], 1);
    @(negedge clk);
    chk("out_v_single", out_v[idx], 0);
  endtask

  task automatic send(input int idx, input int val, input bit relu);
    accept_s(idx, val, relu);
    complete_s(idx, 1'b0, 0);
  endtask

  task automatic pulse_rst(input int idx);
    rst[idx] = 1'b1;
    #1;
    chk("rst_out_v", out_v[idx], 0);
    chk("rst_in_ready", in_ready[idx], 1);
    chk("rst_conv_rst", conv_rst[idx], 1);
    chk("rst_a3", a3[idx], '0);
    chk("rst_err", err[idx], 0);
    hcnt[idx]    = 0;
    err_exp[idx] = 1'b0;
    @(negedge clk);
    rst[idx] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; in_data[i] = '0; in_v[i] = 1'b0; apply_relu[i] = 1'b0;
      out_ready[i] = 1'b1; stub_en[i] = 1'b1; err_exp[i] = 1'b0; hcnt[i] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_in_ready", in_ready[i], 1);
      chk("reset_conv_rst", conv_rst[i], 1);
      chk("reset_out_v", out_v[i], 0);
      chk("reset_out_data", out_data[i], '0);
      chk("reset_err", err[i], 0);
      chk("reset_taps", a0[i] | a1[i] | a2[i] | a3[i], '0);
      chk("reset_relu", conv_relu[i], 0);
    end
    chk("reset_wptr", 128'(u_k1.u_cache.wptr), 0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // reset in the middle of WAIT wipes the in-flight result and the history
    send(0, 1, 1'b0);
    accept_s(0, 2, 1'b1);
    repeat (3) @(negedge clk);
    chk("in_wait_conv_rst", conv_rst[0], 0);
    void'(sb.pop_front());
    pulse_rst(0);
    accept_s(0, 9, 1'b0);
    complete_s(0, 1'b0, 0);

    // fill-up with K=2: taps at 3rd = (0,0,1,3), at 7th = (1,3,5,7)
    pulse_rst(0);
    for (int v = 1; v <= 7; v++) send(0, v, 1'(v % 2));

    // backpressure: output parked for 20 cycles
    out_ready[0] = 1'b0;
    accept_s(0, 8, 1'b1);
    complete_s(0, 1'b0, 20);

    // timeout, then normal completion with err held
    stub_en[0] = 1'b0;
    accept_s(0, 11, 1'b0);
    complete_s(0, 1'b1, 0);
    stub_en[0] = 1'b1;
    send(0, 12, 1'b1);
    chk("err_sticky", err[0], 1);

    // wrap-around with K=1, N=4
    for (int v = 1; v <= 10; v++) send(1, v, 1'(v % 2));
    chk("wrap_a0", a0[1], vec(7));
    chk("wrap_wptr", 128'(u_k1.u_cache.wptr), 2);
    chk("k1_err", err[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
